hilo_md_ctrl: RTL and testbench
===============================

// Module: hilo_md_ctrl
// PURPOSE
//  Sequencer for the EX-stage multiply/divide resources and owner of the HI/LO registers.
//  - Launches MULT/MULTU on the shared multiplier and DIV/DIVU on the iterative divider.
//  - Holds EX via stall_req until the operation completes, then commits HI/LO.
//  - Executes MTHI/MTLO directly and exposes HI/LO for MFHI/MFLO forwarding.
// PARAMETERS
//  MUL_CYCLES  2  multiplier latency in cycles, from operands valid to result valid (>=1)
// PORTS
//  clk           in   1   clock
//  resetn        in   1   synchronous active-low reset
//  op_valid      in   1   EX holds a mul/div/mt op; held stable while stall_req=1
//  op_code       in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, others ignored
//  op_a          in   32  rs value (dividend / multiplicand / MT source)
//  op_b          in   32  rt value (divisor / multiplier)
//  flush         in   1   abort any in-flight op; HI/LO untouched
//  stall_req     out  1   EX stall request, asserted while an op is in flight
//  mul_signed    out  1   to multiplier
//  mul_ina       out  32  to multiplier
//  mul_inb       out  32  to multiplier
//  mul_result    in   64  multiplier product, valid MUL_CYCLES after launch
//  div_start     out  1   to divider, held high until div_ready
//  div_signed    out  1   to divider
//  div_opa       out  32  to divider
//  div_opb       out  32  to divider
//  div_annul     out  1   one-cycle divider cancel on flush
//  div_ready     in   1   divider done; div_result valid this cycle
//  div_result    in   64  {remainder, quotient}
//  hi            out  32  HI register
//  lo            out  32  LO register
//  hilo_we       out  1   one-cycle pulse when HI or LO is written
// BEHAVIOUR
//  Reset (resetn=0 at a clk edge):
//  - State IDLE; hi=lo=0; cnt=0.
//  - All outputs 0: stall_req, div_start, div_annul, hilo_we, mul_*, div_*.
//  States: IDLE, MUL_WAIT, DIV_WAIT, DONE.
//  IDLE:
//  - op_valid with MULT/MULTU: capture operands, mul_signed = (op_code==0), cnt=MUL_CYCLES-1,
//    go to MUL_WAIT. stall_req is asserted combinationally in this same cycle.
//  - op_valid with DIV/DIVU: capture operands, div_signed = (op_code==2), go to DIV_WAIT;
//    stall_req is combinational in this cycle; div_start=1 from the next cycle.
//  - MTHI/MTLO: write hi (or lo) from op_a at this edge, hilo_we=1 for one cycle,
//    no stall, stay in IDLE.
//  MUL_WAIT:
//  - mul_ina/mul_inb/mul_signed held stable; stall_req=1; cnt decrements each cycle.
//  - At cnt==0: hi=mul_result[63:32], lo=mul_result[31:0], hilo_we=1, go to DONE.
//  DIV_WAIT:
//  - div_start=1 and div operands held; stall_req=1.
//  - On div_ready: hi=div_result[63:32], lo=div_result[31:0], hilo_we=1,
//    div_start drops, go to DONE.
//  DONE:
//  - stall_req=0 so EX advances. op_valid is ignored this cycle, so the same
//    instruction is not relaunched. Go to IDLE.
//  Flush:
//  - In any state: go to IDLE next cycle, stall_req=0, no HI/LO write.
//  - In DIV_WAIT only, also pulse div_annul for one cycle.
//  - flush coincident with div_ready or cnt==0: flush wins and the result is discarded.
//  Other rules:
//  - Reset mid-operation aborts without a write.
//  - Latency: MULT = MUL_CYCLES+1 stall cycles; DIV = divider latency + 1.
// CONFIGURATION
//  MD_DIVZERO_BYPASS_EN
//  - defined: DIV/DIVU with op_b==0 bypasses the divider. It takes one stall cycle, goes
//    IDLE->DONE, writes hi=op_a, lo=32'hFFFF_FFFF, hilo_we=1; div_start stays 0.
//  - undefined: divide-by-zero goes through the divider like any other divide; HI/LO take
//    whatever div_result reports.
// TESTING
//  1. MULT a=-3 (FFFFFFFD), b=5, MUL_CYCLES=2 -> stall_req 3 cycles; hi=FFFFFFFF,
//     lo=FFFFFFF1; one hilo_we pulse.
//  2. MULTU a=FFFFFFFF, b=2 -> hi=00000001, lo=FFFFFFFE.
//  3. DIV a=-7, b=2, model divider ready after 33 cycles -> div_signed=1;
//     hi=FFFFFFFF, lo=FFFFFFFD; stall drops in the DONE cycle; no relaunch while
//     op_valid stays high.
//  4. MTHI 12345678 then MTLO 9ABCDEF0 back to back -> no stall;
//     hi=12345678, lo=9ABCDEF0; two hilo_we pulses.
//  5. DIVU in flight, assert flush together with div_ready -> div_annul pulse,
//     hi/lo unchanged, IDLE next cycle.
//  6. DIV op_b=0, op_a=0000000A with MD_DIVZERO_BYPASS_EN -> one stall cycle,
//     hi=0000000A, lo=FFFFFFFF, div_start never high.

Source files
------------

// File: rtl/hilo_md_ctrl.sv
// hilo_md_ctrl: EX-stage multiply/divide sequencer and owner of the HI/LO registers.
// Launches MULT/MULTU on the shared multiplier and DIV/DIVU on the iterative
// divider, stalls EX while an operation is in flight, then commits HI/LO.
// MTHI/MTLO are written directly without stalling.
// Optional feature macro: MD_DIVZERO_BYPASS_EN -- when defined, a divide by zero
// completes locally in one stall cycle (hi = op_a, lo = all ones) and the
// divider is never started.
module hilo_md_ctrl #(
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [2:0]  op_code,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    output logic        stall_req,
    output logic        mul_signed,
    output logic [31:0] mul_ina,
    output logic [31:0] mul_inb,
    input  logic [63:0] mul_result,
    output logic        div_start,
    output logic        div_signed,
    output logic [31:0] div_opa,
    output logic [31:0] div_opb,
    output logic        div_annul,
    input  logic        div_ready,
    input  logic [63:0] div_result,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        hilo_we
);

    localparam int unsigned    CNT_W    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL_WAIT,
        DIV_WAIT,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;

    logic        is_mul;
    logic        is_div;
    logic        is_mthi;
    logic        is_mtlo;
    logic        launch_mul;
    logic        launch_div;
    logic        wr_hi;
    logic        wr_lo;
    logic [31:0] hi_nxt;
    logic [31:0] lo_nxt;

    assign is_mul  = op_valid && ((op_code == 3'd0) || (op_code == 3'd1));
    assign is_div  = op_valid && ((op_code == 3'd2) || (op_code == 3'd3));
    assign is_mthi = op_valid && (op_code == 3'd4);
    assign is_mtlo = op_valid && (op_code == 3'd5);

    // The divider request is simply "waiting on the divider"; it falls when
    // the commit moves us to DONE.
    assign div_start = (state == DIV_WAIT);

`ifdef MD_DIVZERO_BYPASS_EN
    logic div_by_zero;
    assign div_by_zero = (op_b == '0);
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, stall/annul outputs and HI/LO write decode; flush overrides
    // every state so a result arriving in the flush cycle is discarded.
    always_comb begin
        state_nxt  = state;
        stall_req  = 1'b0;
        div_annul  = 1'b0;
        launch_mul = 1'b0;
        launch_div = 1'b0;
        wr_hi      = 1'b0;
        wr_lo      = 1'b0;
        hi_nxt     = hi;
        lo_nxt     = lo;
        if (flush) begin
            state_nxt = IDLE;
            div_annul = (state == DIV_WAIT);
        end else begin
            case (state)
                IDLE: begin
                    if (is_mul) begin
                        stall_req  = 1'b1;
                        launch_mul = 1'b1;
                        state_nxt  = MUL_WAIT;
                    end else if (is_div) begin
                        stall_req = 1'b1;
`ifdef MD_DIVZERO_BYPASS_EN
                        if (div_by_zero) begin
                            wr_hi     = 1'b1;
                            wr_lo     = 1'b1;
                            hi_nxt    = op_a;
                            lo_nxt    = '1;
                            state_nxt = DONE;
                        end else begin
                            launch_div = 1'b1;
                            state_nxt  = DIV_WAIT;
                        end
`else
                        launch_div = 1'b1;
                        state_nxt  = DIV_WAIT;
`endif
                    end else if (is_mthi) begin
                        wr_hi  = 1'b1;
                        hi_nxt = op_a;
                    end else if (is_mtlo) begin
                        wr_lo  = 1'b1;
                        lo_nxt = op_a;
                    end
                end
                MUL_WAIT: begin
                    stall_req = 1'b1;
                    if (cnt == '0) begin
                        wr_hi     = 1'b1;
                        wr_lo     = 1'b1;
                        hi_nxt    = mul_result[63:32];
                        lo_nxt    = mul_result[31:0];
                        state_nxt = DONE;
                    end
                end
                DIV_WAIT: begin
                    stall_req = 1'b1;
                    if (div_ready) begin
                        wr_hi     = 1'b1;
                        wr_lo     = 1'b1;
                        hi_nxt    = div_result[63:32];
                        lo_nxt    = div_result[31:0];
                        state_nxt = DONE;
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // HI/LO, write pulse, latency counter and held operand registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hi         <= '0;
            lo         <= '0;
            hilo_we    <= 1'b0;
            cnt        <= '0;
            mul_signed <= 1'b0;
            mul_ina    <= '0;
            mul_inb    <= '0;
            div_signed <= 1'b0;
            div_opa    <= '0;
            div_opb    <= '0;
        end else begin
            hilo_we <= wr_hi || wr_lo;
            if (wr_hi) begin
                hi <= hi_nxt;
            end
            if (wr_lo) begin
                lo <= lo_nxt;
            end
            if (launch_mul) begin
                mul_signed <= (op_code == 3'd0);
                mul_ina    <= op_a;
                mul_inb    <= op_b;
                cnt        <= CNT_INIT;
            end else if ((state == MUL_WAIT) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            if (launch_div) begin
                div_signed <= (op_code == 3'd2);
                div_opa    <= op_a;
                div_opb    <= op_b;
            end
        end
    end

endmodule

// File: tb/tb_hilo_md_ctrl.sv
// tb_hilo_md_ctrl: scoreboard bench for hilo_md_ctrl with behavioural
// multiplier/divider models and randomized operation mix.
`timescale 1ns/1ps
module tb_hilo_md_ctrl;

    localparam int unsigned MUL_CYCLES = 2;
`ifdef MD_DIVZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op_code = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic        stall_req;
    logic        mul_signed;
    logic [31:0] mul_ina;
    logic [31:0] mul_inb;
    logic [63:0] mul_result;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_opa;
    logic [31:0] div_opb;
    logic        div_annul;
    logic        div_ready;
    logic [63:0] div_result;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        hilo_we;

    hilo_md_ctrl #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .op_valid   (op_valid),
        .op_code    (op_code),
        .op_a       (op_a),
        .op_b       (op_b),
        .flush      (flush),
        .stall_req  (stall_req),
        .mul_signed (mul_signed),
        .mul_ina    (mul_ina),
        .mul_inb    (mul_inb),
        .mul_result (mul_result),
        .div_start  (div_start),
        .div_signed (div_signed),
        .div_opa    (div_opa),
        .div_opb    (div_opb),
        .div_annul  (div_annul),
        .div_ready  (div_ready),
        .div_result (div_result),
        .hi         (hi),
        .lo         (lo),
        .hilo_we    (hilo_we)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int div_lat_cfg = 1;
    int div_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Architectural product: signed or unsigned 32x32 -> 64.
    function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint pa, pb;
        if (s) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
        end else begin
            pa = longint'({32'b0, a});
            pb = longint'({32'b0, b});
        end
        return 64'(pa * pb);
    endfunction

    // Architectural divide: {remainder, quotient}, truncating toward zero;
    // the modelled divider reports {dividend, all ones} for a zero divisor.
    function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Environment: multiplier output follows its held operands; divider
    // reports ready after div_lat_cfg cycles of div_start.
    assign mul_result = mul_ref(mul_ina, mul_inb, mul_signed);
    assign div_ready  = div_start && (div_cnt == div_lat_cfg - 1);
    assign div_result = div_ready ? div_ref(div_opa, div_opb, div_signed) : 64'hDEAD_BEEF_DEAD_BEEF;

    always @(posedge clk) begin
        if (!div_start || div_ready || div_annul) div_cnt <= 0;
        else div_cnt <= div_cnt + 1;
    end

    // Scoreboard monitor: every HI/LO write pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (resetn && hilo_we) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL hilo_we_unexpected: got hi/lo %h_%h with no write expected", hi, lo);
            end else begin
                check("hilo_commit", {hi, lo}, exp_q.pop_front());
            end
        end
    end

    // fmode: 0 none, 1 flush at stall-loop cycle fcyc, 2 flush together with div_ready.
    task automatic run_op(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                          input int lat, input int fmode, input int fcyc);
        bit mul_op, div_op, div_path, writes, flushed, done;
        int active, exp_stalls, stalls, annuls, starts, exp_annul;
        logic [31:0] nhi, nlo;
        logic [63:0] r;
        mul_op   = (code <= 3'd1);
        div_op   = (code == 3'd2) || (code == 3'd3);
        div_path = div_op && !(BYPASS && (b == 32'd0));
        nhi = m_hi;
        nlo = m_lo;
        writes = 1'b0;
        exp_stalls = 0;
        if (mul_op) begin
            r = mul_ref(a, b, code == 3'd0);
            nhi = r[63:32]; nlo = r[31:0]; writes = 1'b1;
            exp_stalls = MUL_CYCLES + 1;
        end else if (div_op) begin
            r = div_ref(a, b, code == 3'd2);
            nhi = r[63:32]; nlo = r[31:0]; writes = 1'b1;
            exp_stalls = div_path ? lat + 1 : 1;
        end else if (code == 3'd4) begin
            nhi = a; writes = 1'b1;
        end else if (code == 3'd5) begin
            nlo = a; writes = 1'b1;
        end
        active  = (exp_stalls > 0) ? exp_stalls : 1;
        flushed = (fmode == 2) || ((fmode == 1) && (fcyc < active));
        exp_annul = (div_path && flushed && ((fmode == 2) || (fcyc >= 1))) ? 1 : 0;
        if (writes && !flushed) begin
            exp_q.push_back({nhi, nlo});
            m_hi = nhi;
            m_lo = nlo;
        end
        div_lat_cfg = lat;
        op_valid = 1'b1; op_code = code; op_a = a; op_b = b;
        stalls = 0; annuls = 0; starts = 0; done = 1'b0;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            flush = ((fmode == 1) && (cyc == fcyc)) || ((fmode == 2) && div_ready);
            #1;
            if (stall_req) stalls++;
            if (div_annul) annuls++;
            if (div_start) starts++;
            if ((cyc == 1) && !((fmode == 1) && (fcyc == 0))) begin
                if (mul_op) begin
                    check("mul_operands", {mul_ina, mul_inb}, {a, b});
                    check("mul_signed", 64'(mul_signed), 64'(code == 3'd0));
                end
                if (div_path) begin
                    check("div_operands", {div_opa, div_opb}, {a, b});
                    check("div_signed", 64'(div_signed), 64'(code == 3'd2));
                end
            end
            done = !stall_req;
            @(posedge clk); #1;
            flush = 1'b0;
        end
        check("op_completes", 64'(done), 64'd1);
        op_valid = 1'b0;
        #1;
        if (!flushed) begin
            check("stall_cycles", 64'(stalls), 64'(exp_stalls));
            check("div_start_cycles", 64'(starts), 64'(div_path ? lat : 0));
        end else begin
            check("post_flush_stall", 64'(stall_req), 64'd0);
        end
        check("div_annul_pulses", 64'(annuls), 64'(exp_annul));
        check("hilo_state", {hi, lo}, {m_hi, m_lo});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] code;
        logic [31:0] a, b;
        int lat, fm, fc, sel;
        bit dp;

        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        #1;
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_mul_ops", {mul_ina, mul_inb}, 64'd0);
        check("reset_div_ops", {div_opa, div_opb}, 64'd0);
        check("reset_ctrl", {58'b0, stall_req, div_start, div_annul, hilo_we, mul_signed, div_signed}, 64'd0);

        // Directed cases with hand-derived constants.
        run_op(3'd0, 32'hFFFF_FFFD, 32'd5, 10, 0, 0);
        check("t1_mult", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 10, 0, 0);
        check("t2_multu", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 33, 0, 0);
        check("t3_div", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'd4, 32'h1234_5678, 32'd0, 1, 0, 0);
        run_op(3'd5, 32'h9ABC_DEF0, 32'd0, 1, 0, 0);
        check("t4_mt", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
        run_op(3'd3, 32'd100, 32'd7, 12, 2, 0);
        check("t5_flush_ready", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
        run_op(3'd2, 32'h0000_000A, 32'd0, 5, 0, 0);
        check("t6_divzero", {hi, lo}, 64'h0000_000A_FFFF_FFFF);
        run_op(3'd0, 32'd7, 32'd9, 1, 1, MUL_CYCLES);
        check("flush_at_mul_commit", {hi, lo}, 64'h0000_000A_FFFF_FFFF);

        // Reset in the middle of a divide: no commit, HI/LO cleared.
        div_lat_cfg = 30;
        op_valid = 1'b1; op_code = 3'd2; op_a = 32'd1000; op_b = 32'd3;
        repeat (5) @(posedge clk);
        #1;
        check("stall_mid_div", 64'(stall_req), 64'd1);
        resetn = 1'b0;
        op_valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        m_hi = '0;
        m_lo = '0;
        #1;
        check("reset_mid_op_hilo", {hi, lo}, 64'd0);
        check("reset_mid_op_ctrl", {62'b0, stall_req, div_start}, 64'd0);

        // Randomized operation mix.
        for (int n = 0; n < 150; n++) begin
            code = 3'($urandom_range(0, 7));
            a = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) b = 32'($urandom_range(1, 9));
            else if (sel == 2) b = 32'hFFFF_FFFF;
            else b = $urandom;
            if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
            lat = $urandom_range(1, 40);
            dp = ((code == 3'd2) || (code == 3'd3)) && !(BYPASS && (b == 32'd0));
            fm = 0;
            fc = 0;
            sel = $urandom_range(0, 9);
            if (sel == 0) begin
                fm = 1;
                fc = $urandom_range(0, 4);
            end else if ((sel == 1) && dp) begin
                fm = 2;
            end
            run_op(code, a, b, lat, fm, fc);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
